// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/hazard resolution with a per-register countdown
// scoreboard. Producers of any latency stall their dependents for exactly the
// required number of cycles; flush and bus-wait priority is resolved here too.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush[2:0]      NOFLUSH=0, FLUSHM=1 (jump), FLUSHW=2 (exception/interrupt)
//   ibus_not_busy   instruction bus ready
//   dbus_not_busy   data bus ready
//   fu_busy         per multi-cycle unit busy (unit occupies E)
//   d_valid, d_src1/2, d_use1/2, d_we, d_dst, d_lat   decode-stage instruction
//   stop[2:0]       combinational stall code: NOSTALL=0 STALLF=1 STALLE=2
//                   STALLM=3 STALLW=4
//   hazard_busy     any scoreboard entry non-zero
//   perf_*          (HAZARD_PERF_EN only) 32-bit stall-cycle counters
//
// Optional feature macro: HAZARD_PERF_EN
module hazard_ctrl #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned NUM_FU = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              flush,
  input  logic                    ibus_not_busy,
  input  logic                    dbus_not_busy,
  input  logic [NUM_FU-1:0]       fu_busy,
  input  logic                    d_valid,
  input  logic [$clog2(NREG)-1:0] d_src1,
  input  logic [$clog2(NREG)-1:0] d_src2,
  input  logic                    d_use1,
  input  logic                    d_use2,
  input  logic                    d_we,
  input  logic [$clog2(NREG)-1:0] d_dst,
  input  logic [CNT_W-1:0]        d_lat,
  output logic [2:0]              stop,
  output logic                    hazard_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             perf_stf,
  output logic [31:0]             perf_ste,
  output logic [31:0]             perf_stm,
  output logic [31:0]             perf_stw,
  output logic [31:0]             perf_raw
`endif
);

  localparam int unsigned IDX_W = $clog2(NREG);

  localparam logic [2:0] NOFLUSH = 3'd0;
  localparam logic [2:0] FLUSHM  = 3'd1;
  localparam logic [2:0] FLUSHW  = 3'd2;

  localparam logic [2:0] NOSTALL = 3'd0;
  localparam logic [2:0] STALLF  = 3'd1;
  localparam logic [2:0] STALLE  = 3'd2;
  localparam logic [2:0] STALLM  = 3'd3;
  localparam logic [2:0] STALLW  = 3'd4;

  logic [CNT_W-1:0] r_cnt [NREG];
  logic             r_e_live;
  logic [IDX_W-1:0] r_e_dst;

  logic w_raw;
  logic w_flush_req;
  logic w_run;
  logic w_flush_take;
  logic w_rec;

  // RAW: a read source still has an outstanding countdown (x0 never hazards)
  always_comb begin
    w_raw = 1'b0;
    if (d_valid) begin
      if (d_use1 && (d_src1 != '0) && (r_cnt[d_src1] != '0)) w_raw = 1'b1;
      if (d_use2 && (d_src2 != '0) && (r_cnt[d_src2] != '0)) w_raw = 1'b1;
    end
  end

  // Stall priority, first match wins
  always_comb begin
    stop = NOSTALL;
    if (flush == FLUSHW)
      stop = (ibus_not_busy && dbus_not_busy) ? NOSTALL : STALLW;
    else if (flush == FLUSHM)
      stop = ibus_not_busy ? NOSTALL : STALLM;
    else if (!dbus_not_busy)
      stop = STALLM;
    else if (w_raw)
      stop = STALLE;
    else if (|fu_busy)
      stop = STALLE;
    else if (!ibus_not_busy)
      stop = STALLF;
  end

  // Backend moves unless M/W are frozen; D->E issue only without a flush
  assign w_flush_req  = (flush == FLUSHM) || (flush == FLUSHW);
  assign w_run        = (stop != STALLM) && (stop != STALLW);
  assign w_flush_take = w_flush_req && (stop == NOSTALL);
  assign w_rec        = ((stop == NOSTALL) || (stop == STALLF)) && d_valid &&
                        !w_flush_req && d_we && (d_dst != '0) && (d_lat != '0);

  always_comb begin
    hazard_busy = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (r_cnt[IDX_W'(i)] != '0) hazard_busy = 1'b1;
  end

  // Scoreboard: decrement, then kill the flushed E entry, then a new issue
  // overrides (later non-blocking assignment wins on the same index)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[IDX_W'(i)] <= '0;
      r_e_live <= 1'b0;
      r_e_dst  <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NREG; i++)
        if (r_cnt[IDX_W'(i)] != '0)
          r_cnt[IDX_W'(i)] <= r_cnt[IDX_W'(i)] - CNT_W'(1);
      if (w_flush_take && r_e_live) r_cnt[r_e_dst] <= '0;
      if (w_rec) begin
        r_cnt[d_dst] <= d_lat;
        r_e_dst      <= d_dst;
      end
      r_e_live <= w_rec;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stf;
  logic [31:0] r_perf_ste;
  logic [31:0] r_perf_stm;
  logic [31:0] r_perf_stw;
  logic [31:0] r_perf_raw;

  // Free-running wrapping stall-cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stf <= '0;
      r_perf_ste <= '0;
      r_perf_stm <= '0;
      r_perf_stw <= '0;
      r_perf_raw <= '0;
    end else begin
      if (stop == STALLF) r_perf_stf <= r_perf_stf + 32'd1;
      if (stop == STALLE) r_perf_ste <= r_perf_ste + 32'd1;
      if (stop == STALLM) r_perf_stm <= r_perf_stm + 32'd1;
      if (stop == STALLW) r_perf_stw <= r_perf_stw + 32'd1;
      if ((stop == STALLE) && w_raw) r_perf_raw <= r_perf_raw + 32'd1;
    end
  end

  assign perf_stf = r_perf_stf;
  assign perf_ste = r_perf_ste;
  assign perf_stm = r_perf_stm;
  assign perf_stw = r_perf_stw;
  assign perf_raw = r_perf_raw;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline's combinational stall unit, sitting in the hazard path between decode/execute and the stage registers.
- Replaces fixed load-use detection with a per-register countdown scoreboard, so producers of any latency (loads, multi-cycle ALU ops) stall dependents for exactly the required cycles.
- Generalises the single `done` input to a busy vector over NUM_FU multi-cycle units.
- Keeps the flush/bus-wait priority resolution and emits one stall code per cycle.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hard-wired zero and never hazards.
- CNT_W, 3, width of each scoreboard countdown; maximum producer latency is 2^CNT_W-1.
- NUM_FU, 2, number of multi-cycle execute units reporting busy.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  3  flush_t request: NOFLUSH, FLUSHM (jump), FLUSHW (exception/interrupt)
- ibus_not_busy  in  1  instruction bus idle/ready
- dbus_not_busy  in  1  data bus idle/ready
- fu_busy  in  NUM_FU  per-unit busy; unit is occupied in E
- d_valid  in  1  decode holds a valid instruction
- d_src1, d_src2  in  $clog2(NREG) each  source register indices
- d_use1, d_use2  in  1 each  source actually read
- d_we  in  1  instruction writes a register
- d_dst  in  $clog2(NREG)  destination index
- d_lat  in  CNT_W  cycles after E-entry until result is forwardable; 0 means forwardable immediately
- stop  out  3  stall_t: NOSTALL=0, STALLF=1, STALLE=2, STALLM=3, STALLW=4
- hazard_busy  out  1  any scoreboard entry non-zero (debug/idle indication)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: all scoreboard counters 0; e_live 0; stop is combinational and reads NOSTALL with idle inputs; hazard_busy 0.
- stop priority, combinational, first match wins:
  - FLUSHW with both buses ready → NOSTALL.
  - FLUSHW otherwise → STALLW.
  - FLUSHM with ibus ready → NOSTALL.
  - FLUSHM otherwise → STALLM.
  - !dbus_not_busy → STALLM.
  - RAW hazard → STALLE. RAW = d_valid && ((d_use1 && d_src1!=0 && cnt[d_src1]!=0) || (d_use2 && d_src2!=0 && cnt[d_src2]!=0)).
  - |fu_busy → STALLE.
  - !ibus_not_busy → STALLF.
  - else NOSTALL.
- Issue: D advances to E when stop ∈ {NOSTALL, STALLF}, d_valid=1 and flush==NOFLUSH. On issue with d_we && d_dst!=0 && d_lat!=0: cnt[d_dst] ← d_lat, e_dst ← d_dst, e_live ← 1.
  - Any other advance, including issue with d_lat=0 or an E bubble caused by STALLE: e_live ← 0.
- Decrement: every cycle stop ∉ {STALLM, STALLW}, each non-zero counter decrements by 1 (backend frozen otherwise). Counters never wrap below 0.
- Issue and decrement on the same index in the same cycle: issue value wins, undecremented.
- Flush taken (flush!=NOFLUSH and stop==NOSTALL):
  - If e_live, cnt[e_dst] ← 0, since the E instruction is killed.
  - e_live ← 0.
  - Entries of older instructions (already past E) keep decrementing.
  - No issue is recorded that cycle.
- Flush pending but stalled (STALLM/STALLW): no scoreboard change.
- Single-cycle load (d_lat=1) with a dependent immediately behind gives exactly one STALLE cycle.
- hazard_busy = OR of all counters non-zero.
- reset asserted mid-operation clears all state on the next edge regardless of other inputs.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stf, perf_ste, perf_stm, perf_stw (32 bits each). Each is a free-running wrapping counter incremented on every cycle stop equals the respective code; all cleared by reset.
  - perf_raw (32 bits) counts STALLE cycles caused by RAW specifically, excluding fu_busy.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle with buses ready → stop=NOSTALL, hazard_busy=0, all counters 0.
- Issue d_dst=5, d_lat=1; next cycle decode reads d_src1=5 → stop=STALLE for exactly 1 cycle, then NOSTALL.
- Issue d_dst=7, d_lat=4 (multiplier); dependent on src2=7 follows → 4 STALLE cycles; with dbus_not_busy=0 for 2 of them, stop=STALLM there and the countdown holds, giving 4 STALLE cycles total.
- Issue d_dst=9, d_lat=3; next cycle flush=FLUSHM, ibus ready → stop=NOSTALL, cnt[9]=0; later reader of 9 is not stalled. Repeat with ibus_not_busy=0 → STALLM until ready.
- Writer to x0 with d_lat=3; reader of x0 → no STALLE; fu_busy=2'b10 → STALLE; FLUSHW with dbus busy → STALLW (priority over fu_busy).
- With HAZARD_PERF_EN: 3 RAW stalls + 2 fu_busy stalls + 1 STALLF → perf_ste=5, perf_raw=3, perf_stf=1.
